// File: rtl/ysyx_22040895_pcu_pkg.sv
// rtl/ysyx_22040895_pcu_pkg.sv - shared fetch-unit state encoding, widths and reset PC
`ifndef YSYX_22040895_REGBUS_W
`define YSYX_22040895_REGBUS_W 64
`endif

package ysyx_22040895_pcu_pkg;

    localparam int          PCU_XLEN     = `YSYX_22040895_REGBUS_W;
    localparam int          PCU_INST_W   = 32;
    localparam logic [63:0] PCU_RESET_PC = 64'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } pcu_state_e;

endpackage

// File: rtl/ysyx_22040895_pcu_outbuf.sv
// rtl/ysyx_22040895_pcu_outbuf.sv - single-entry {inst, pc, valid} register towards decode
module ysyx_22040895_pcu_outbuf #(
    parameter int XLEN   = 64,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic              ready,
    input  logic [INST_W-1:0] inst_in,
    input  logic [XLEN-1:0]   pc_in,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            inst  <= '0;
            pc    <= '0;
        end else begin
            // flush wins over a same-cycle handshake: the held entry is simply dropped
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
                inst  <= inst_in;
                pc    <= pc_in;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ysyx_22040895_pcu.sv
// rtl/ysyx_22040895_pcu.sv - PC register and fetch FSM; optional YSYX_22040895_PCU_MISALIGN_CHK_EN
module ysyx_22040895_pcu
    import ysyx_22040895_pcu_pkg::*;
#(
    parameter int              XLEN     = PCU_XLEN,
    parameter int              INST_W   = PCU_INST_W,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(PCU_RESET_PC)
) (
    input  logic              clk_i_pcu,
    input  logic              rst_n_i_pcu,
    input  logic              jump_branch_i_pcu,
    input  logic [XLEN-1:0]   dnpc_i_pcu,
    input  logic              jump_i_pcu,
    input  logic [XLEN-1:0]   jtarget_i_pcu,
    output logic              imem_req_o_pcu,
    output logic [XLEN-1:0]   imem_addr_o_pcu,
    input  logic              imem_gnt_i_pcu,
    input  logic              imem_rvalid_i_pcu,
    input  logic [INST_W-1:0] imem_rdata_i_pcu,
    output logic              inst_valid_o_pcu,
    input  logic              inst_ready_i_pcu,
    output logic [INST_W-1:0] inst_o_pcu,
    output logic [XLEN-1:0]   pc_o_pcu,
    output logic              misalign_o_pcu
);

    pcu_state_e      state;
    logic [XLEN-1:0] pc;
    logic            misalign_q;

    logic            redir;
    logic [XLEN-1:0] target;
    logic            tgt_bad;
    logic            park;
    pcu_state_e      resume_state;
    logic            load;

    // redirects are ignored while IDLE; the branch unit has priority over jal/jalr
    assign redir  = (jump_branch_i_pcu | jump_i_pcu) && (state != S_IDLE);
    assign target = jump_branch_i_pcu ? dnpc_i_pcu : jtarget_i_pcu;

`ifdef YSYX_22040895_PCU_MISALIGN_CHK_EN
    assign tgt_bad = redir && (target[1:0] != 2'b00);
`else
    assign tgt_bad = 1'b0;
`endif

    // once a bad target has been seen, anything that would refetch parks in IDLE instead
    assign park         = misalign_q | tgt_bad;
    assign resume_state = park ? S_IDLE : S_REQ;
    assign load         = (state == S_WAIT) && imem_rvalid_i_pcu && !redir;

    always_ff @(posedge clk_i_pcu or negedge rst_n_i_pcu) begin
        if (!rst_n_i_pcu) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            misalign_q <= 1'b0;
        end else if (redir) begin
            if (tgt_bad) begin
                misalign_q <= 1'b1;
            end else begin
                pc <= target;
            end
            case (state)
                S_REQ:   state <= imem_gnt_i_pcu    ? S_DROP       : resume_state;
                S_WAIT:  state <= imem_rvalid_i_pcu ? resume_state : S_DROP;
                S_HOLD:  state <= resume_state;
                S_DROP:  state <= imem_rvalid_i_pcu ? resume_state : S_DROP;
                default: state <= state;
            endcase
        end else begin
            case (state)
                S_IDLE: if (!misalign_q) state <= S_REQ;
                S_REQ:  if (imem_gnt_i_pcu) state <= S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid_i_pcu) begin
                        pc    <= pc + XLEN'(4);
                        state <= S_HOLD;
                    end
                end
                S_HOLD: if (inst_ready_i_pcu) state <= S_REQ;
                S_DROP: if (imem_rvalid_i_pcu) state <= resume_state;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign imem_req_o_pcu  = (state == S_REQ);
    assign imem_addr_o_pcu = pc;
    assign misalign_o_pcu  = misalign_q;

    ysyx_22040895_pcu_outbuf #(
        .XLEN   (XLEN),
        .INST_W (INST_W)
    ) u_outbuf (
        .clk     (clk_i_pcu),
        .rst_n   (rst_n_i_pcu),
        .load    (load),
        .flush   (redir),
        .ready   (inst_ready_i_pcu),
        .inst_in (imem_rdata_i_pcu),
        .pc_in   (pc),
        .valid   (inst_valid_o_pcu),
        .inst    (inst_o_pcu),
        .pc      (pc_o_pcu)
    );

endmodule
